// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci/Galois LFSR with lockup recovery and valid/ready output.
// Optional period counter is compiled in when LFSR_PERIOD_CNT_EN is defined.
module lfsr_gen #(
    parameter int               WIDTH = 14,
    parameter logic [WIDTH-1:0] TAPS  = 14'h3802,
    parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             lockup,
    output logic [WIDTH-1:0] period_cnt,
    output logic             period_hit
);

    typedef enum logic [1:0] {IDLE, RUN, LOCK} state_t;

    state_t           st;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] fib_next;
    logic [WIDTH-1:0] gal_next;
    logic [WIDTH-1:0] nxt;
    logic             zero;
    logic             step;

    assign fib_next = {s[WIDTH-2:0], ^(s & TAPS)};
    assign gal_next = {s[WIDTH-2:0], s[WIDTH-1]} ^
                      ({WIDTH{s[WIDTH-1]}} & {TAPS[WIDTH-2:0], 1'b0});
    assign nxt      = mode ? gal_next : fib_next;
    assign zero     = (s == '0);
    // A zero state diverts to LOCK instead of stepping; en=0 drops valid without a transfer.
    assign step     = (st == RUN) && out_valid && out_ready && en && !zero;
    assign out_data = s;

    always_ff @(posedge clk) begin
        if (rst) begin
            s         <= SEED;
            st        <= IDLE;
            out_valid <= 1'b0;
            lockup    <= 1'b0;
        end else if (load) begin
            s         <= load_val;
            lockup    <= 1'b0;
            st        <= en ? RUN : IDLE;
            out_valid <= en;
        end else begin
            case (st)
                IDLE: begin
                    if (en) begin
                        st        <= RUN;
                        out_valid <= 1'b1;
                    end
                end
                RUN: begin
                    if (zero) begin
                        st        <= LOCK;
                        out_valid <= 1'b0;
                        lockup    <= 1'b1;
                    end else if (!en) begin
                        st        <= IDLE;
                        out_valid <= 1'b0;
                    end else if (step) begin
                        s <= nxt;
                    end
                end
                LOCK: begin
                    s         <= SEED;
                    st        <= en ? RUN : IDLE;
                    out_valid <= en;
                end
                default: begin
                    st        <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef LFSR_PERIOD_CNT_EN
    logic [WIDTH-1:0] ref_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            ref_val    <= SEED;
            period_cnt <= '0;
            period_hit <= 1'b0;
        end else begin
            period_hit <= 1'b0;
            if (load) begin
                ref_val    <= load_val;
                period_cnt <= '0;
            end else if (st == LOCK) begin
                ref_val    <= SEED;
                period_cnt <= '0;
            end else if (step) begin
                if (nxt == ref_val) begin
                    period_cnt <= '0;
                    period_hit <= 1'b1;
                end else begin
                    period_cnt <= period_cnt + 1'b1;
                end
            end
        end
    end
`else
    assign period_cnt = '0;
    assign period_hit = 1'b0;
`endif

endmodule
